// File: rtl/axi_bw_regulator_pkg.sv
// Shared types and constants for the per-core AXI bandwidth regulator.
// Holds the counter width, the configuration bundle and the per-core reset-time defaults.
package axi_bw_regulator_pkg;

    localparam int unsigned BwRegCntWidth = 32;
    localparam int unsigned BwRegLenWidth = 8;
    localparam int unsigned BwRegNumCores = 4;

    localparam logic [BwRegCntWidth-1:0] BwRegDefaultPeriod = 32'd1000;
    localparam logic [BwRegCntWidth-1:0] BwRegDefaultBudget = 32'd256;

    typedef struct packed {
        logic                     en;
        logic [BwRegCntWidth-1:0] period;
        logic [BwRegCntWidth-1:0] budget;
    } bw_reg_cfg_t;

    // Core 0 gets the full default budget, the other cores half of it
    function automatic bw_reg_cfg_t bw_reg_default_cfg(input int unsigned core_idx);
        bw_reg_cfg_t cfg;
        cfg.en     = 1'b0;
        cfg.period = BwRegDefaultPeriod;
        if (core_idx == 32'd0) begin
            cfg.budget = BwRegDefaultBudget;
        end else begin
            cfg.budget = BwRegDefaultBudget >> 1;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/axi_bw_regulator_chan_gate.sv
// One AXI address channel gate: holds back new requests while the budget is empty,
// but never withdraws a valid that has already been presented downstream.
module axi_bw_regulator_chan_gate
    import axi_bw_regulator_pkg::*;
#(
    parameter int unsigned LenWidth = BwRegLenWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                budget_ok_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [LenWidth-1:0] len_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [LenWidth:0]   beats_o
);

    logic r_lock;
    logic w_pass;
    logic w_hs;

    // Valid/ready gating and beat count of the current handshake
    always_comb begin
        w_pass  = ~en_i | r_lock | budget_ok_i;
        valid_o = valid_i & w_pass;
        ready_o = ready_i & valid_o;
        w_hs    = valid_o & ready_i;
        if (w_hs) begin
            beats_o = {1'b0, len_i} + {{LenWidth{1'b0}}, 1'b1};
        end else begin
            beats_o = {(LenWidth + 1){1'b0}};
        end
    end

    // Lock keeps an issued-but-unaccepted valid stable until its handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock <= 1'b0;
        end else if (w_hs) begin
            r_lock <= 1'b0;
        end else if (valid_o) begin
            r_lock <= 1'b1;
        end else begin
            r_lock <= r_lock;
        end
    end

endmodule

// File: rtl/axi_bw_regulator.sv
// Per-core memory bandwidth regulator: limits AR/AW data beats per regulation period
// and reports throttling state and held-request statistics.
module axi_bw_regulator
    import axi_bw_regulator_pkg::*;
#(
    parameter int unsigned CntWidth = BwRegCntWidth,
    parameter int unsigned LenWidth = BwRegLenWidth,
    parameter int unsigned CoreIdx  = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [CntWidth-1:0] period_i,
    input  logic [CntWidth-1:0] budget_i,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    input  logic [LenWidth-1:0] ar_len_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [LenWidth-1:0] aw_len_i,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic                throttled_o,
    output logic [CntWidth-1:0] budget_left_o,
    output logic [CntWidth-1:0] stall_cycles_o
);

    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth - 1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CntOnes = {CntWidth{1'b1}};

    if (CoreIdx >= BwRegNumCores) begin : g_core_idx_unmapped
    end

    logic [CntWidth-1:0] r_period_cnt;
    logic [CntWidth-1:0] r_period_q;
    logic [CntWidth-1:0] r_budget_left;
    logic [CntWidth-1:0] r_stall_cnt;

    logic [LenWidth:0]   w_ar_beats;
    logic [LenWidth:0]   w_aw_beats;
    logic [CntWidth-1:0] w_period_eff;
    logic [CntWidth-1:0] w_consumed;
    logic [CntWidth-1:0] w_base;
    logic [CntWidth-1:0] w_budget_nxt;
    logic                w_wrap;
    logic                w_stall;
    logic                w_budget_ok;

    assign w_budget_ok = (r_budget_left != CntZero);

    axi_bw_regulator_chan_gate #(
        .LenWidth (LenWidth)
    ) u_ar_gate (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .budget_ok_i (w_budget_ok),
        .valid_i     (ar_valid_i),
        .ready_o     (ar_ready_o),
        .len_i       (ar_len_i),
        .valid_o     (ar_valid_o),
        .ready_i     (ar_ready_i),
        .beats_o     (w_ar_beats)
    );

    axi_bw_regulator_chan_gate #(
        .LenWidth (LenWidth)
    ) u_aw_gate (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .budget_ok_i (w_budget_ok),
        .valid_i     (aw_valid_i),
        .ready_o     (aw_ready_o),
        .len_i       (aw_len_i),
        .valid_o     (aw_valid_o),
        .ready_i     (aw_ready_i),
        .beats_o     (w_aw_beats)
    );

    // Wrap detection and saturating next-budget computation
    always_comb begin
        if (r_period_q == CntZero) begin
            w_period_eff = CntOne;
        end else begin
            w_period_eff = r_period_q;
        end
        w_wrap     = (r_period_cnt >= (w_period_eff - CntOne));
        w_consumed = CntWidth'(w_ar_beats) + CntWidth'(w_aw_beats);
        // On a wrap the freshly sampled budget is the base, so no debt carries over
        if (w_wrap) begin
            w_base = budget_i;
        end else begin
            w_base = r_budget_left;
        end
        if (w_consumed >= w_base) begin
            w_budget_nxt = CntZero;
        end else begin
            w_budget_nxt = w_base - w_consumed;
        end
        w_stall = (ar_valid_i & ~ar_valid_o) | (aw_valid_i & ~aw_valid_o);
    end

    // Period counter, period latch and remaining budget; bypass parks the period
    // at zero so the first enabled cycle latches config from that cycle's inputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_period_cnt  <= CntZero;
            r_period_q    <= CntZero;
            r_budget_left <= CntZero;
        end else if (!en_i) begin
            r_period_cnt  <= CntZero;
            r_period_q    <= CntZero;
            r_budget_left <= budget_i;
        end else if (w_wrap) begin
            r_period_cnt  <= CntZero;
            r_period_q    <= period_i;
            r_budget_left <= w_budget_nxt;
        end else begin
            r_period_cnt  <= r_period_cnt + CntOne;
            r_period_q    <= r_period_q;
            r_budget_left <= w_budget_nxt;
        end
    end

    // Saturating count of cycles where the regulator held a request back
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= CntZero;
        end else if (w_stall && (r_stall_cnt != CntOnes)) begin
            r_stall_cnt <= r_stall_cnt + CntOne;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign throttled_o    = en_i & ~w_budget_ok;
    assign budget_left_o  = r_budget_left;
    assign stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_axi_bw_regulator.sv
// Self-checking bench for axi_bw_regulator: scenario tasks with a scoreboard of
// expected handshake cycles and expected budget values.
module tb_axi_bw_regulator;

    localparam int CW = 32;
    localparam int LW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          en_i = 1'b0;
    logic [CW-1:0] period_i = '0;
    logic [CW-1:0] budget_i = '0;
    logic          ar_valid_i = 1'b0;
    logic          ar_ready_o;
    logic [LW-1:0] ar_len_i = '0;
    logic          ar_valid_o;
    logic          ar_ready_i = 1'b0;
    logic          aw_valid_i = 1'b0;
    logic          aw_ready_o;
    logic [LW-1:0] aw_len_i = '0;
    logic          aw_valid_o;
    logic          aw_ready_i = 1'b0;
    logic          throttled_o;
    logic [CW-1:0] budget_left_o;
    logic [CW-1:0] stall_cycles_o;

    int n_cmp = 0;
    int n_err = 0;
    int            exp_hs_q[$];
    logic [CW-1:0] exp_bl_q[$];

    axi_bw_regulator #(.CntWidth(CW), .LenWidth(LW), .CoreIdx(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
        .period_i(period_i), .budget_i(budget_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_len_i(ar_len_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_len_i(aw_len_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .throttled_o(throttled_o), .budget_left_o(budget_left_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0; ar_len_i = '0;
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; aw_len_i = '0;
    endtask

    // Leaves the bench at the falling edge of period cycle 0 with a full budget
    task automatic do_reset(input logic [CW-1:0] per, input logic [CW-1:0] bud);
        @(negedge clk_i);
        rst_ni = 1'b0; en_i = 1'b0; period_i = per; budget_i = bud;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1; en_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic pop_budget(input string name);
        logic [CW-1:0] e;
        n_cmp++;
        if (exp_bl_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected budget queued, got %0d", name, budget_left_o);
        end else begin
            e = exp_bl_q.pop_front();
            if (budget_left_o !== e) begin
                n_err++;
                $display("FAIL %s: budget_left got %0d expected %0d", name, budget_left_o, e);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; en_i = 1'b0; period_i = 32'd100; budget_i = 32'd5;
        idle_inputs();
        #1;
        n_cmp++;
        if (budget_left_o !== 32'd0) begin n_err++; $display("FAIL reset_budget: got %0d expected 0", budget_left_o); end
        n_cmp++;
        if (stall_cycles_o !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles_o); end
        n_cmp++;
        if ({throttled_o, ar_valid_o, aw_valid_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000", {throttled_o, ar_valid_o, aw_valid_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (budget_left_o !== 32'd5) begin n_err++; $display("FAIL post_reset_budget: got %0d expected 5", budget_left_o); end
    endtask

    task automatic test_throttle();
        do_reset(32'd100, 32'd16);
        for (int k = 0; k < 4; k++) exp_hs_q.push_back(k);
        exp_hs_q.push_back(100);
        for (int c = 0; c <= 100; c++) begin
            ar_valid_i = 1'b1; ar_len_i = 8'd3; ar_ready_i = 1'b1;
            #1;
            if (ar_valid_i && ar_ready_o) begin
                n_cmp++;
                if (exp_hs_q.size() == 0) begin
                    n_err++; $display("FAIL throttle_hs: unexpected handshake at cycle %0d", c);
                end else if (c !== exp_hs_q[0]) begin
                    n_err++; $display("FAIL throttle_hs: handshake at cycle %0d expected %0d", c, exp_hs_q.pop_front());
                end else begin
                    void'(exp_hs_q.pop_front());
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (budget_left_o !== 32'd0 || throttled_o !== 1'b1) begin
                    n_err++; $display("FAIL throttle_empty: budget %0d thr %b expected 0 1", budget_left_o, throttled_o);
                end
            end
            if (c == 100) begin
                n_cmp++;
                if (stall_cycles_o !== 32'd96) begin n_err++; $display("FAIL throttle_stall: got %0d expected 96", stall_cycles_o); end
                n_cmp++;
                if (budget_left_o !== 32'd16) begin n_err++; $display("FAIL throttle_reload: got %0d expected 16", budget_left_o); end
            end
            @(negedge clk_i);
        end
        idle_inputs();
        n_cmp++;
        if (exp_hs_q.size() != 0) begin
            n_err++; $display("FAIL throttle_missing: %0d handshakes outstanding expected 0", exp_hs_q.size());
        end
        exp_hs_q.delete();
    endtask

    task automatic test_simultaneous();
        do_reset(32'd100, 32'd16);
        ar_valid_i = 1'b1; ar_len_i = 8'd5; ar_ready_i = 1'b1;
        exp_bl_q.push_back(32'd10);
        @(negedge clk_i);
        #1;
        pop_budget("simul_pre");
        ar_len_i = 8'd7;
        aw_valid_i = 1'b1; aw_len_i = 8'd7; aw_ready_i = 1'b1;
        #1;
        exp_bl_q.push_back(32'd0);
        n_cmp++;
        if ({ar_ready_o, aw_ready_o} !== 2'b11) begin
            n_err++; $display("FAIL simul_both_hs: got %b expected 11", {ar_ready_o, aw_ready_o});
        end
        @(negedge clk_i);
        #1;
        pop_budget("simul_sat");
        n_cmp++;
        if ({throttled_o, ar_valid_o, aw_valid_o} !== 3'b100) begin
            n_err++; $display("FAIL simul_blocked: got %b expected 100", {throttled_o, ar_valid_o, aw_valid_o});
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset(32'd100, 32'd4);
        ar_valid_i = 1'b1; ar_len_i = 8'd0; ar_ready_i = 1'b0;
        aw_valid_i = 1'b1; aw_len_i = 8'd3; aw_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({ar_valid_o, aw_ready_o} !== 2'b11) begin
            n_err++; $display("FAIL lock_issue: got %b expected 11", {ar_valid_o, aw_ready_o});
        end
        exp_bl_q.push_back(32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            aw_valid_i = 1'b0; aw_ready_i = 1'b0;
            #1;
            if (c == 1) pop_budget("lock_budget");
            n_cmp++;
            if ({throttled_o, ar_valid_o, ar_ready_o} !== 3'b110) begin
                n_err++; $display("FAIL lock_hold: cycle %0d got %b expected 110", c, {throttled_o, ar_valid_o, ar_ready_o});
            end
        end
        @(negedge clk_i);
        ar_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({ar_valid_o, ar_ready_o} !== 2'b11) begin
            n_err++; $display("FAIL lock_complete: got %b expected 11", {ar_valid_o, ar_ready_o});
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (ar_valid_o !== 1'b0) begin n_err++; $display("FAIL lock_after: ar_valid_o got %b expected 0", ar_valid_o); end
        idle_inputs();
    endtask

    task automatic test_config_change();
        do_reset(32'd100, 32'd16);
        for (int c = 0; c <= 100; c++) begin
            if (c == 30) budget_i = 32'd4;
            #1;
            if (c == 50 || c == 99) begin
                n_cmp++;
                if (budget_left_o !== 32'd16) begin n_err++; $display("FAIL cfg_hold: cycle %0d got %0d expected 16", c, budget_left_o); end
            end
            if (c == 100) begin
                n_cmp++;
                if (budget_left_o !== 32'd4) begin n_err++; $display("FAIL cfg_reload: got %0d expected 4", budget_left_o); end
            end
            @(negedge clk_i);
        end
    endtask

    // Continues from test_config_change: bench sits at period cycle 101
    task automatic test_wrap_handshake();
        for (int c = 101; c <= 200; c++) begin
            if (c == 150) budget_i = 32'd8;
            if (c == 199) begin
                aw_valid_i = 1'b1; aw_len_i = 8'd1; aw_ready_i = 1'b1;
                exp_bl_q.push_back(32'd6);
            end else begin
                idle_inputs();
            end
            #1;
            if (c == 199) begin
                n_cmp++;
                if (aw_ready_o !== 1'b1) begin n_err++; $display("FAIL wrap_hs: aw_ready_o got %b expected 1", aw_ready_o); end
            end
            if (c == 200) pop_budget("wrap_budget");
            @(negedge clk_i);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        do_reset(32'd100, 32'd16);
        en_i = 1'b0; budget_i = 32'd0;
        @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            ar_valid_i = 1'b1; ar_len_i = 8'd7; ar_ready_i = 1'b1;
            aw_valid_i = 1'b1; aw_len_i = 8'd7; aw_ready_i = 1'b1;
            #1;
            n_cmp++;
            if ({ar_ready_o, aw_ready_o, throttled_o} !== 3'b110 || budget_left_o !== 32'd0) begin
                n_err++; $display("FAIL bypass_pass: k=%0d got %b/%0d expected 110/0", k, {ar_ready_o, aw_ready_o, throttled_o}, budget_left_o);
            end
            @(negedge clk_i);
        end
        en_i = 1'b1;
        #1;
        n_cmp++;
        if ({ar_valid_o, aw_valid_o, throttled_o} !== 3'b001) begin
            n_err++; $display("FAIL enable_block: got %b expected 001", {ar_valid_o, aw_valid_o, throttled_o});
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if (ar_valid_o !== 1'b0 || stall_cycles_o !== 32'd1) begin
            n_err++; $display("FAIL enable_stall: valid %b stall %0d expected 0 1", ar_valid_o, stall_cycles_o);
        end
        idle_inputs();
    endtask

    task automatic test_period_zero();
        do_reset(32'd0, 32'd2);
        for (int c = 0; c < 6; c++) begin
            ar_valid_i = 1'b1; ar_len_i = 8'd0; ar_ready_i = 1'b1;
            exp_bl_q.push_back((c == 0) ? 32'd2 : 32'd1);
            #1;
            n_cmp++;
            if (ar_ready_o !== 1'b1) begin n_err++; $display("FAIL period0_hs: cycle %0d got %b expected 1", c, ar_ready_o); end
            pop_budget("period0_budget");
            @(negedge clk_i);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_throttle();
        test_simultaneous();
        test_lock();
        test_config_change();
        test_wrap_handshake();
        test_bypass();
        test_period_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_bw_regulator.md
Name: axi_bw_regulator

Overview:
- Per-core memory-bandwidth regulator between one CVA6 core AXI master (axi_masters_t Core_0..Core_3) and the SoC crossbar, upstream of the partitioned LLC and HyperRAM.
- Gates AR/AW address handshakes so a core consumes at most a programmed number of data beats per regulation period. Data channels pass through untouched.
- One instance per core; SPU/PMU reads its status outputs.

Parameters:
- CntWidth, 32, width of period, budget and statistic counters
- LenWidth, 8, width of the AXI AxLEN field
- CoreIdx, 0, axi_masters_t index of the regulated core; reporting only

Ports:
- clk_i  in  1  SoC clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  regulation enable; 0 = transparent bypass
- period_i  in  CntWidth  regulation period in cycles; 0 is treated as 1
- budget_i  in  CntWidth  beats allowed per period
- ar_valid_i  in  1  AR valid from the core
- ar_ready_o  out  1  AR ready to the core
- ar_len_i  in  LenWidth  AR burst length minus 1
- ar_valid_o  out  1  AR valid to the crossbar
- ar_ready_i  in  1  AR ready from the crossbar
- aw_valid_i  in  1  AW valid from the core
- aw_ready_o  out  1  AW ready to the core
- aw_len_i  in  LenWidth  AW burst length minus 1
- aw_valid_o  out  1  AW valid to the crossbar
- aw_ready_i  in  1  AW ready from the crossbar
- throttled_o  out  1  budget exhausted; new requests held off
- budget_left_o  out  CntWidth  remaining beats in the current period
- stall_cycles_o  out  CntWidth  cycles with a request held by the regulator; saturating

Behaviour:
- Reset values: period_cnt=0, budget_left=budget_i sampled at the first cycle after reset (register reset value 0), ar/aw lock flags=0, throttled_o=0, stall_cycles_o=0.
- Config latch: period_q and budget_q are captured from period_i/budget_i only at a period wrap. Changing the inputs mid-period has no effect until the next wrap.
- Period counter: increments every cycle. When period_cnt == max(period_q,1)-1 it wraps to 0, reloads budget_left := budget_q (new values), and latches the new config.
- Gate rule: a new request may present valid downstream only if budget_left != 0.
  - ar_valid_o = ar_valid_i & (ar_lock | budget_left != 0); same for AW.
  - ar_ready_o = ar_ready_i & ar_valid_o.
- Lock (AXI stability): once ar_valid_o=1 without ar_ready_i, ar_lock=1. Valid then stays high until the handshake, regardless of budget exhaustion, reload or en_i change. The lock clears on handshake. AW identical.
- Consumption: on an AR handshake subtract ar_len_i+1; on an AW handshake subtract aw_len_i+1.
  - Both in the same cycle: subtract the sum.
  - Result saturates at 0. The final burst may overshoot; no debt carries over.
- Reload coincident with handshake(s): budget_left := budget_q_new - consumed, saturating at 0.
- throttled_o = en_i & (budget_left == 0). Combinational from the register.
- stall_cycles_o increments on every cycle where (ar_valid_i & ~ar_valid_o) | (aw_valid_i & ~aw_valid_o). It holds at all-ones.
- Bypass (en_i=0):
  - ar/aw valid and ready pass straight through; locked transactions still complete.
  - Period counter is held at 0; budget_left is held at budget_i.
  - A 0->1 transition on en_i starts a fresh period: counter 0, config latched from the inputs that cycle.
- budget_i == 0 with en_i=1: all new requests blocked indefinitely; locked ones complete.
- Latency: zero-cycle combinational path valid/ready when not throttled. No added pipeline stage.
- Reset asserted mid-transaction: all state clears asynchronously. Upstream is reset in the same domain, so no handshake recovery is required.

Decomposition:
- Shared package (ariane_soc): BwRegCntWidth constant; bw_reg_cfg_t packed struct {en, period, budget}; default period/budget per core.
- One sub-module: bw_reg_chan_gate, instantiated once for AR and once for AW. It contains the lock flop, the valid/ready gating and the handshake beat count. The top holds the period counter, the budget register and the stall statistics.

Test Plan:
- en=1, period=100, budget=16, one AR len=3 handshake per cycle:
  - 4 handshakes accepted in cycles 0-3, budget_left=0, throttled_o=1.
  - Next AR is held until cycle 100, then accepted.
  - stall_cycles_o=96.
- Simultaneous AR len=7 and AW len=7 handshake with budget_left=10 -> budget_left saturates to 0, throttled_o=1. Both transactions complete.
- AR presented with budget_left=0 but ar_lock=1 (valid issued earlier, ar_ready_i low 5 cycles):
  - ar_valid_o stays 1 throughout.
  - Handshake completes on the first ready; no further AR issues.
- budget_i changed 16->4 at cycle 30 of a 100-cycle period -> budget_left keeps counting from 16 until the cycle-99 wrap, then reloads to 4.
- AW len=1 handshake on the exact wrap cycle with budget_q_new=8 -> budget_left=6 next cycle.
- en=0, budget=0 -> full throughput, throttled_o=0. Then en 0->1 -> period starts at 0 and the next request is blocked.
